// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256/SHA-224 constants, round functions and FSM state type
// Purpose: shared definitions for the sha256_stream hashing core.
// Contents: word type, state enum, legal unroll mask, K table, IV256/IV224,
//           big/small sigma, Ch and Maj helpers.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_ADD,
    S_DONE
  } state_t;

  // Bit n set means n rounds per cycle is a legal unroll factor (1, 2, 4, 8).
  localparam int unsigned RPC_LEGAL_MASK = 32'h0000_0116;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// rtl/sha256_stream_if.sv - block/digest handshake bundle for sha256_stream
// Purpose: groups the block input stream, digest output and status lines.
// master: block source / digest sink (drives in_*, digest_ready).
// slave : hashing core (drives in_ready, digest, digest_valid, busy, seq_err).
interface sha256_stream_if;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         in_mode224;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;
  logic         seq_err;

  modport master (
    output in_block, in_first, in_last, in_mode224, in_valid, digest_ready,
    input  in_ready, digest, digest_valid, busy, seq_err
  );

  modport slave (
    input  in_block, in_first, in_last, in_mode224, in_valid, digest_ready,
    output in_ready, digest, digest_valid, busy, seq_err
  );
endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
// Purpose: computes a'..h' from a..h, K[t] and W[t].
// Ports: st_i {a..h} (a in [255:224]), k_i round constant, w_i schedule word,
//        st_o {a'..h'}.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_i,
  input  word_t        k_i,
  input  word_t        w_i,
  output logic [255:0] st_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_i;
  assign t1   = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2   = big_sigma0(a) + maj(a, b, c);
  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - multi-block SHA-256/SHA-224 core with chained hash
// Purpose: hashes a stream of pre-padded 512-bit blocks, R rounds per clock.
// Ports: clk, reset_n (async active-low), bus (sha256_stream_if.slave):
//        in_block/in_first/in_last/in_mode224/in_valid/in_ready block beat,
//        digest/digest_valid/digest_ready result, busy and seq_err status.
module sha256_stream
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  sha256_stream_if.slave bus
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam bit R_LEGAL = (R > 0) && (((RPC_LEGAL_MASK >> R) & 32'd1) != 0);

  generate
    if (!R_LEGAL) begin : g_bad_rpc
      $error("sha256_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [255:0]      h_q, h_d;
  logic [255:0]      wv_q, wv_d;
  logic [255:0]      digest_q, digest_d;
  logic [15:0][31:0] w_q, w_d;
  logic              last_q, last_d;
  logic              mode_q, mode_d;
  logic              open_q, open_d;
  logic              seq_err_q, seq_err_d;
  logic              in_ready_q, in_ready_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;

  logic [255:0]        h_sum;
  logic [255:0]        h_eff;
  logic [16+R-1:0][31:0] ext;
  logic [255:0]        rs [R+1];

  // Schedule window w_q[0] holds W[t]; ext appends the next R words so the
  // window can slide by R while the rounds consume ext[0..R-1].
  always_comb begin
    ext       = '0;
    ext[15:0] = w_q;
    for (int j = 0; j < R; j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
  end

  assign rs[0] = wv_q;
  for (genvar j = 0; j < R; j++) begin : g_round
    sha256_round u_round (
      .st_i (rs[j]),
      .k_i  (K[cnt_q + 6'(j)]),
      .w_i  (ext[j]),
      .st_o (rs[j+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    wv_d      = wv_q;
    w_d       = w_q;
    last_d    = last_q;
    mode_d    = mode_q;
    open_d    = open_q;
    digest_d  = digest_q;
    seq_err_d = 1'b0;

    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + wv_q[32*i +: 32];
    end

    // A continuation block with no message open is treated as a fresh start.
    h_eff = (bus.in_first || !open_q) ? (bus.in_mode224 ? IV224 : IV256) : h_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = bus.in_block[511-32*i -: 32];
          end
          if (bus.in_first || !open_q) begin
            mode_d    = bus.in_mode224;
            open_d    = 1'b1;
            seq_err_d = !bus.in_first;
          end
          cnt_d   = '0;
          last_d  = bus.in_last;
          h_d     = h_eff;
          wv_d    = h_eff;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d  = rs[R];
        w_d   = ext[R+15:R];
        cnt_d = cnt_q + 6'(R);
        if (cnt_q == 6'(64 - R)) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        h_d = h_sum;
        if (last_q) begin
          open_d   = 1'b0;
          digest_d = mode_q ? {h_sum[255:32], 32'd0} : h_sum;
          state_d  = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.digest_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    dv_d       = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      h_q        <= '0;
      wv_q       <= '0;
      w_q        <= '0;
      digest_q   <= '0;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      open_q     <= 1'b0;
      seq_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      wv_q       <= wv_d;
      w_q        <= w_d;
      digest_q   <= digest_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      open_q     <= open_d;
      seq_err_q  <= seq_err_d;
      in_ready_q <= in_ready_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = dv_q;
  assign bus.busy         = busy_q;
  assign bus.seq_err      = seq_err_q;

endmodule

// File: tb/tb_sha256_stream.sv
// tb/tb_sha256_stream.sv - self-checking bench for sha256_stream at R = 1, 2, 4, 8
module tb_sha256_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [511:0] blk_a [4];
  logic [3:0]   valid_a, first_a, last_a, mode_a, dr_a;
  logic [3:0]   rdy_a, dv_a, busy_a, se_a;
  logic [255:0] dig_a [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   msg_q [$];
  logic [511:0] blk_q [$];

  localparam logic [255:0] D_ABC    = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam string        S_TWO    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  localparam int unsigned TB_IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam int unsigned TB_IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam int unsigned TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_stream_if bus ();
    assign bus.in_block     = blk_a[g];
    assign bus.in_first     = first_a[g];
    assign bus.in_last      = last_a[g];
    assign bus.in_mode224   = mode_a[g];
    assign bus.in_valid     = valid_a[g];
    assign bus.digest_ready = dr_a[g];
    assign rdy_a[g]         = bus.in_ready;
    assign dv_a[g]          = bus.digest_valid;
    assign busy_a[g]        = bus.busy;
    assign se_a[g]          = bus.seq_err;
    assign dig_a[g]         = bus.digest;
    sha256_stream #(.ROUNDS_PER_CYCLE(1 << g)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  // ---------------- reference model (FIPS 180-4, full 64-word schedule) ----
  function automatic int unsigned rr(input int unsigned x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input bit m224);
    int unsigned hv [8];
    int unsigned s [8];
    int unsigned w [64];
    int unsigned t1, t2;
    logic [511:0] blk;
    logic [255:0] r;
    hv = m224 ? TB_IV224 : TB_IV256;
    for (int b = 0; b < blk_q.size(); b++) begin
      blk = blk_q[b];
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      s = hv;
      for (int t = 0; t < 64; t++) begin
        t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + TB_K[t] + w[t];
        t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        for (int i = 7; i > 0; i--) s[i] = s[i-1];
        s[4] = s[4] + t1;
        s[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hv[i] = hv[i] + s[i];
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i];
    if (m224) r[31:0] = '0;
    return r;
  endfunction

  task automatic set_string(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic build_blocks();
    logic [7:0]      p [$];
    longint unsigned bitlen;
    logic [511:0]    v;
    p = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8 * i)));
    blk_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v = {v[503:0], p[b*64+j]};
      blk_q.push_back(v);
    end
  endtask

  // ---------------- drivers (observe only, no checking) -------------------
  task automatic run_msg(input int k, input bit m224, input bit use_first,
                         output logic [255:0] dig, output int lat,
                         output bit se_first, output bit se_other, output bit tmo);
    int n;
    tmo = 0; se_first = 0; se_other = 0; lat = 0; dig = '0;
    for (int i = 0; i < blk_q.size(); i++) begin
      blk_a[k]   = blk_q[i];
      first_a[k] = (i == 0) && use_first;
      last_a[k]  = (i == blk_q.size() - 1);
      mode_a[k]  = (i == 0) ? m224 : 1'($urandom);
      valid_a[k] = 1'b1;
      n = 0;
      while (!rdy_a[k] && n < 300) begin @(negedge clk); n++; end
      if (!rdy_a[k]) begin tmo = 1; valid_a[k] = 1'b0; return; end
      @(negedge clk);
      valid_a[k] = 1'b0;
      if (i == 0) se_first = se_a[k]; else se_other = se_other | se_a[k];
    end
    n = 0;
    while (!dv_a[k] && n < 300) begin @(negedge clk); n++; end
    lat = n;
    if (!dv_a[k]) tmo = 1;
    dig = dig_a[k];
  endtask

  task automatic ack_digest(input int k, output bit idle_ok);
    dr_a[k] = 1'b1;
    @(negedge clk);
    dr_a[k] = 1'b0;
    idle_ok = !dv_a[k] && rdy_a[k] && !busy_a[k];
  endtask

  task automatic send_partial(input int k, input logic [511:0] blk, output bit tmo);
    int n;
    blk_a[k] = blk; first_a[k] = 1'b1; last_a[k] = 1'b0; mode_a[k] = 1'b0; valid_a[k] = 1'b1;
    n = 0;
    while (!rdy_a[k] && n < 300) begin @(negedge clk); n++; end
    tmo = !rdy_a[k];
    @(negedge clk);
    valid_a[k] = 1'b0;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({rdy_a[k], dv_a[k], busy_a[k], se_a[k]} !== 4'b0) begin
        n_fail++; $display("FAIL reset_flags[%0d]: got %b expected 0000", k, {rdy_a[k], dv_a[k], busy_a[k], se_a[k]});
      end
      n_tests++;
      if (dig_a[k] !== '0) begin n_fail++; $display("FAIL reset_digest[%0d]: got %h expected 0", k, dig_a[k]); end
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (rdy_a !== 4'h0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0000", rdy_a); end
    @(negedge clk);
    n_tests++;
    if (rdy_a !== 4'hf) begin n_fail++; $display("FAIL ready_after_edge: got %b expected 1111", rdy_a); end
  endtask

  task automatic test_abc();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string("abc"); build_blocks();
    run_msg(0, 1'b0, 1'b1, dig, lat, sf, so, tmo);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL abc_timeout: got 1 expected 0"); end
    n_tests++; if (dig !== D_ABC) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", dig, D_ABC); end
    n_tests++; if (lat != 65) begin n_fail++; $display("FAIL abc_latency: got %0d expected 65", lat); end
    n_tests++; if (sf) begin n_fail++; $display("FAIL abc_seq_err: got 1 expected 0"); end
    ack_digest(0, idle);
    n_tests++; if (!idle) begin n_fail++; $display("FAIL abc_idle_after_ack: got 0 expected 1"); end
  endtask

  task automatic test_two_block_unroll();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string(S_TWO); build_blocks();
    for (int k = 0; k < 4; k++) begin
      run_msg(k, 1'b0, 1'b1, dig, lat, sf, so, tmo);
      n_tests++; if (tmo) begin n_fail++; $display("FAIL two_timeout[R=%0d]: got 1 expected 0", 1 << k); end
      n_tests++; if (dig !== D_TWO) begin n_fail++; $display("FAIL two_digest[R=%0d]: got %h expected %h", 1 << k, dig, D_TWO); end
      n_tests++;
      if (lat != 64 / (1 << k) + 1) begin
        n_fail++; $display("FAIL two_latency[R=%0d]: got %0d expected %0d", 1 << k, lat, 64 / (1 << k) + 1);
      end
      n_tests++; if (sf || so) begin n_fail++; $display("FAIL two_seq_err[R=%0d]: got 1 expected 0", 1 << k); end
      ack_digest(k, idle);
      n_tests++; if (!idle) begin n_fail++; $display("FAIL two_idle[R=%0d]: got 0 expected 1", 1 << k); end
    end
  endtask

  task automatic test_sha224();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string("abc"); build_blocks();
    run_msg(1, 1'b1, 1'b1, dig, lat, sf, so, tmo);
    n_tests++; if (dig !== D_ABC224) begin n_fail++; $display("FAIL sha224_digest: got %h expected %h", dig, D_ABC224); end
    ack_digest(1, idle);
    n_tests++; if (!idle) begin n_fail++; $display("FAIL sha224_idle: got 0 expected 1"); end
  endtask

  task automatic test_hold_digest();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string(""); build_blocks();
    run_msg(0, 1'b0, 1'b1, dig, lat, sf, so, tmo);
    n_tests++; if (dig !== D_EMPTY) begin n_fail++; $display("FAIL empty_digest: got %h expected %h", dig, D_EMPTY); end
    // Offer a competing block during the hold; it must not be taken.
    blk_a[0] = {16{32'($urandom)}}; first_a[0] = 1'b1; last_a[0] = 1'b1; valid_a[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (dig_a[0] !== D_EMPTY || dv_a[0] !== 1'b1 || rdy_a[0] !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got dv=%b rdy=%b digest=%h expected dv=1 rdy=0 digest=%h",
                           c, dv_a[0], rdy_a[0], dig_a[0], D_EMPTY);
      end
    end
    valid_a[0] = 1'b0;
    ack_digest(0, idle);
    n_tests++; if (!idle) begin n_fail++; $display("FAIL hold_idle_after_ack: got 0 expected 1"); end
  endtask

  task automatic test_reset_mid_round();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string(S_TWO); build_blocks();
    send_partial(0, blk_q[0], tmo);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL midrst_accept_timeout: got 1 expected 0"); end
    repeat (10) @(negedge clk);
    n_tests++; if (busy_a[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", busy_a[0]); end
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({rdy_a[k], dv_a[k], busy_a[k], se_a[k]} !== 4'b0 || dig_a[k] !== '0) begin
        n_fail++; $display("FAIL midrst_values[%0d]: got flags=%b digest=%h expected flags=0000 digest=0",
                           k, {rdy_a[k], dv_a[k], busy_a[k], se_a[k]}, dig_a[k]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_string("abc"); build_blocks();
    run_msg(0, 1'b0, 1'b1, dig, lat, sf, so, tmo);
    n_tests++; if (dig !== D_ABC) begin n_fail++; $display("FAIL midrst_abc_digest: got %h expected %h", dig, D_ABC); end
    ack_digest(0, idle);
  endtask

  task automatic test_seq_err();
    int n; bit idle;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_string("abc"); build_blocks();
    blk_a[2] = blk_q[0]; first_a[2] = 1'b0; last_a[2] = 1'b1; mode_a[2] = 1'b0; valid_a[2] = 1'b1;
    n = 0;
    while (!rdy_a[2] && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    valid_a[2] = 1'b0;
    n_tests++; if (se_a[2] !== 1'b1) begin n_fail++; $display("FAIL seq_err_pulse: got %b expected 1", se_a[2]); end
    @(negedge clk);
    n_tests++; if (se_a[2] !== 1'b0) begin n_fail++; $display("FAIL seq_err_width: got %b expected 0", se_a[2]); end
    n = 0;
    while (!dv_a[2] && n < 300) begin @(negedge clk); n++; end
    n_tests++; if (dig_a[2] !== D_ABC) begin n_fail++; $display("FAIL seq_err_digest: got %h expected %h", dig_a[2], D_ABC); end
    ack_digest(2, idle);
  endtask

  task automatic test_abandon();
    logic [255:0] dig; int lat; bit sf, so, tmo, idle;
    set_string(S_TWO); build_blocks();
    send_partial(3, blk_q[0], tmo);
    set_string("abc"); build_blocks();
    run_msg(3, 1'b0, 1'b1, dig, lat, sf, so, tmo);
    n_tests++; if (dig !== D_ABC) begin n_fail++; $display("FAIL abandon_digest: got %h expected %h", dig, D_ABC); end
    n_tests++; if (sf) begin n_fail++; $display("FAIL abandon_seq_err: got 1 expected 0"); end
    ack_digest(3, idle);
  endtask

  task automatic test_random();
    logic [255:0] dig, exp; int lat, len, k; bit m, sf, so, tmo, idle;
    for (int r = 0; r < 12; r++) begin
      k = r % 4;
      len = $urandom_range(0, 140);
      m = 1'($urandom);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      build_blocks();
      exp = ref_hash(m);
      run_msg(k, m, 1'b1, dig, lat, sf, so, tmo);
      n_tests++;
      if (dig !== exp || tmo) begin
        n_fail++; $display("FAIL rand%0d_digest[R=%0d len=%0d m224=%0d]: got %h expected %h", r, 1 << k, len, m, dig, exp);
      end
      n_tests++;
      if (lat != 64 / (1 << k) + 1) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, lat, 64 / (1 << k) + 1);
      end
      n_tests++; if (sf || so) begin n_fail++; $display("FAIL rand%0d_seq_err: got 1 expected 0", r); end
      ack_digest(k, idle);
      n_tests++; if (!idle) begin n_fail++; $display("FAIL rand%0d_idle: got 0 expected 1", r); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    valid_a = '0; first_a = '0; last_a = '0; mode_a = '0; dr_a = '0;
    for (int k = 0; k < 4; k++) blk_a[k] = '0;
    test_reset();
    test_abc();
    test_two_block_unroll();
    test_sha224();
    test_hold_digest();
    test_reset_mid_round();
    test_seq_err();
    test_abandon();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
